// File: rtl/key_param_ctrl.sv
// rtl/key_param_ctrl.sv - four debounced keys editing freq/phase/amp/waveform with hold-to-repeat
module key_param_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter int FREQ_MIN     = 1,
  parameter int FREQ_MAX     = 100,
  parameter int AMP_MIN      = 1,
  parameter int AMP_MAX      = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_sel,
  input  logic       key_wave,
  input  logic       key_up,
  input  logic       key_down,
  output logic [2:0] state_select,
  output logic [4:0] state_wave,
  output logic [6:0] freq_cnt,
  output logic [7:0] phase_cnt,
  output logic [7:0] amp_cnt,
  output logic       param_chg
);

  localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  typedef enum logic [1:0] {S_FREQ, S_PHASE, S_AMP} sel_t;

  logic [3:0]    key_raw;
  logic [3:0]    sync1, sync2, deb, armed, press;
  logic [DW-1:0] deb_cnt [4];

  assign key_raw = {key_down, key_up, key_wave, key_sel};

  // A key is ignored after reset until it has been seen released for a full
  // debounce window, so a button held through reset never yields an event.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '1;
      armed <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (!armed[i]) begin
          if (sync2[i]) begin
            if (deb_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
              armed[i]   <= 1'b1;
              deb_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
          end else begin
            deb_cnt[i] <= '0;
          end
        end else if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            deb[i]     <= sync2[i];
            press[i]   <= ~sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  logic          up_lo, dn_lo, one_lo;
  logic [HW-1:0] hold_cnt;
  logic          repeating, rep_up, rep_dn;

  assign up_lo  = ~deb[2];
  assign dn_lo  = ~deb[3];
  assign one_lo = up_lo ^ dn_lo;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
      rep_up    <= 1'b0;
      rep_dn    <= 1'b0;
    end else begin
      rep_up <= 1'b0;
      rep_dn <= 1'b0;
      if (!one_lo) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (hold_cnt == (repeating ? HW'(REPEAT_CYC - 1) : HW'(HOLD_CYC - 1))) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
        rep_up    <= up_lo;
        rep_dn    <= dn_lo;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  function automatic logic [7:0] step_range(input logic [7:0] v, input logic inc,
                                            input logic [7:0] lo, input logic [7:0] hi);
    if (inc) return (v >= hi) ? lo : v + 8'd1;
    else     return (v <= lo) ? hi : v - 8'd1;
  endfunction

  logic  sel_evt, wave_evt, inc, dec;
  sel_t  sel_q, sel_nx;
  logic [27:0] prev_q;

  assign sel_evt  = press[0];
  assign wave_evt = press[1];
  // A step is dropped whenever the opposite key is also held down.
  assign inc      = (press[2] | rep_up) & deb[3];
  assign dec      = (press[3] | rep_dn) & deb[2];

  always_comb begin
    sel_nx = sel_q;
    if (sel_evt) begin
      case (sel_q)
        S_FREQ:  sel_nx = S_PHASE;
        S_PHASE: sel_nx = S_AMP;
        default: sel_nx = S_FREQ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q        <= S_FREQ;
      state_select <= 3'b001;
      state_wave   <= 5'b00001;
      freq_cnt     <= 7'(FREQ_MIN);
      phase_cnt    <= 8'd0;
      amp_cnt      <= 8'd50;
      prev_q       <= {5'b00001, 7'(FREQ_MIN), 8'd0, 8'd50};
      param_chg    <= 1'b0;
    end else begin
      sel_q <= sel_nx;
      case (sel_nx)
        S_FREQ:  state_select <= 3'b001;
        S_PHASE: state_select <= 3'b010;
        default: state_select <= 3'b100;
      endcase
      if (wave_evt) state_wave <= {state_wave[3:0], state_wave[4]};
      if (inc ^ dec) begin
        case (sel_nx)
          S_FREQ:  freq_cnt  <= 7'(step_range(8'(freq_cnt), inc, 8'(FREQ_MIN), 8'(FREQ_MAX)));
          S_PHASE: phase_cnt <= inc ? phase_cnt + 8'd1 : phase_cnt - 8'd1;
          default: amp_cnt   <= step_range(amp_cnt, inc, 8'(AMP_MIN), 8'(AMP_MAX));
        endcase
      end
      prev_q    <= {state_wave, freq_cnt, phase_cnt, amp_cnt};
      param_chg <= ({state_wave, freq_cnt, phase_cnt, amp_cnt} != prev_q);
    end
  end

endmodule

// File: doc/key_param_ctrl.md
KEY_PARAM_CTRL -- requirements
Module: key_param_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYC, default 1_000_000, stable-level cycles a key needs before acceptance (20 ms at 50 MHz).
REQ-002 Parameter: HOLD_CYC, default 25_000_000, held-press cycles before auto-repeat starts (500 ms).
REQ-003 Parameter: REPEAT_CYC, default 5_000_000, cycles between auto-repeat steps (100 ms).
REQ-004 Parameter: FREQ_MIN 1 / FREQ_MAX 100, legal freq_cnt range.
REQ-005 Parameter: AMP_MIN 1 / AMP_MAX 100, legal amp_cnt range; phase_cnt range is fixed at 0..255.
REQ-006 sys_clk  input  1  system clock, 50 MHz.
REQ-007 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-008 key_sel  input  1  active-low raw button; cycles the parameter being edited.
REQ-009 key_wave  input  1  active-low raw button; cycles the waveform.
REQ-010 key_up  input  1  active-low raw button; increments the selected parameter.
REQ-011 key_down  input  1  active-low raw button; decrements the selected parameter.
REQ-012 state_select  output  3  one-hot edit target: 001 freq, 010 phase, 100 amp.
REQ-013 state_wave  output  5  one-hot waveform: 00001..10000.
REQ-014 freq_cnt  output  7  frequency setting.
REQ-015 phase_cnt  output  8  phase setting.
REQ-016 amp_cnt  output  8  amplitude setting.
REQ-017 param_chg  output  1  one-cycle pulse in the cycle after any of state_wave, freq_cnt, phase_cnt or amp_cnt changes.

Function
REQ-018 Each key SHALL pass through a 2-flop synchronizer and then a debounce counter. The debounced level SHALL update only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
REQ-019 A press event SHALL be one cycle, generated on the debounced 1->0 transition. Release SHALL generate no event.
REQ-020 Select FSM states SHALL be FREQ -> PHASE -> AMP -> FREQ, advancing on a key_sel event. state_select SHALL be the registered one-hot encoding of the state.
REQ-021 A key_wave event SHALL rotate state_wave left by one bit, with 10000 wrapping to 00001.
REQ-022 A key_up event in FREQ SHALL increment freq_cnt; FREQ_MAX SHALL wrap to FREQ_MIN.
REQ-023 A key_down event in FREQ SHALL decrement freq_cnt; FREQ_MIN SHALL wrap to FREQ_MAX.
REQ-024 Up/down in PHASE SHALL apply modulo 256 (255+1=0, 0-1=255).
REQ-025 Up/down in AMP SHALL follow the same wrap rule as FREQ, using AMP_MIN/AMP_MAX.
REQ-026 Auto-repeat: while exactly one of key_up/key_down stays debounced-low, a hold counter SHALL run. After HOLD_CYC it SHALL generate one step, then one step every REPEAT_CYC, until release. The counter SHALL clear on release.
REQ-027 If key_up and key_down are both debounced-low, no step SHALL occur and auto-repeat SHALL stop. If both events fall in the same cycle, neither SHALL apply.
REQ-028 Same-cycle events priority: key_sel first; then key_wave is applied independently of the others; then up/down are applied to the parameter selected after the key_sel update.
REQ-029 Outputs SHALL update one cycle after the press event (latency 1). param_chg SHALL fire one cycle after the output update (latency 2).
REQ-030 A key_sel event alone SHALL NOT assert param_chg.
REQ-031 Output widths SHALL never overflow; all arithmetic SHALL be range-checked before assignment.

Reset
REQ-032 On sys_rst_n low, all of the following SHALL take effect immediately and asynchronously:
- state_select = 001, state_wave = 00001;
- freq_cnt = 1, phase_cnt = 0, amp_cnt = 50;
- param_chg = 0;
- all debounce/hold counters = 0, debounced levels = 1 (released).
REQ-033 Reset asserted mid-press or mid-repeat SHALL abort with no event. After release, a key still held SHALL not produce an event until it has been released and pressed again.

Verification (DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5)
REQ-034 key_sel low 3 cycles then high, then low 10 cycles -> no change from the short glitch; state_select 001->010 after the valid press.
REQ-035 FREQ selected, freq_cnt=100, key_up press -> freq_cnt=1 and param_chg pulses once. Then key_down press -> freq_cnt=100.
REQ-036 PHASE selected, phase_cnt=0, key_up held 35 cycles past debounce -> one step at press, then steps at hold+0, +5, +10, +15 in sequence, final value 5.
REQ-037 key_wave pressed 5 times -> state_wave sequence 00010, 00100, 01000, 10000, 00001; five param_chg pulses.
REQ-038 key_up and key_down pressed together in AMP with amp_cnt=50 -> amp_cnt stays 50, no param_chg.
REQ-039 Reset asserted during key_up auto-repeat -> outputs return to reset values immediately; key held through reset release -> no step until re-press.
